// File: rtl/rs_pkg.sv
// Shared constants, types and GF(2^5) arithmetic for the RS(31,27) encoder.
package rs_pkg;

    localparam int unsigned SYM_W = 5;
    localparam int unsigned NPAR  = 4;
    localparam int unsigned N_MAX = 31;

    // p(x) = x^5 + x^2 + 1
    localparam logic [SYM_W:0] FIELD_POLY = 6'b10_0101;

    typedef logic [SYM_W-1:0] sym_t;

    // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0
    localparam sym_t G0 = 5'd17;
    localparam sym_t G1 = 5'd9;
    localparam sym_t G2 = 5'd6;
    localparam sym_t G3 = 5'd30;

    typedef enum logic {DATA, PARITY} rs_state_e;

    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[SYM_W-1] ? ((sh << 1) ^ FIELD_POLY[SYM_W-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_encoder_if.sv
// Symbol stream handshake between a data source, the RS encoder and its sink.
interface rs_encoder_if;
    import rs_pkg::*;

    logic in_valid;
    sym_t in_sym;
    logic in_ready;
    logic out_valid;
    sym_t out_sym;
    logic out_last;
    logic out_ready;

    modport master (
        output in_valid, in_sym, out_ready,
        input  in_ready, out_valid, out_sym, out_last
    );

    modport slave (
        input  in_valid, in_sym, out_ready,
        output in_ready, out_valid, out_sym, out_last
    );

endinterface

// File: rtl/gfadder.sv
// GF(2^5) addition.
module gfadder
    import rs_pkg::*;
(
    input  sym_t a,
    input  sym_t b,
    output sym_t y
);

    assign y = a ^ b;

endmodule

// File: rtl/lcpmult.sv
// GF(2^5) multiplier; with one operand tied to a constant it reduces to an XOR network.
module lcpmult
    import rs_pkg::*;
(
    input  sym_t a,
    input  sym_t b,
    output sym_t y
);

    assign y = gf_mul(a, b);

endmodule

// File: rtl/rs_parity_lfsr.sv
// Four-stage parity register: divides the message by g(x) on load, drains p3 first on shift.
module rs_parity_lfsr
    import rs_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic shift,
    input  sym_t fb,
    output sym_t p3
);

    sym_t p0_q, p1_q, p2_q, p3_q;
    sym_t m0, m1, m2, m3;
    sym_t n1, n2, n3;

    lcpmult u_mul0 (.a(fb), .b(G0), .y(m0));
    lcpmult u_mul1 (.a(fb), .b(G1), .y(m1));
    lcpmult u_mul2 (.a(fb), .b(G2), .y(m2));
    lcpmult u_mul3 (.a(fb), .b(G3), .y(m3));

    gfadder u_add1 (.a(p0_q), .b(m1), .y(n1));
    gfadder u_add2 (.a(p1_q), .b(m2), .y(n2));
    gfadder u_add3 (.a(p2_q), .b(m3), .y(n3));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
        end else if (load) begin
            p3_q <= n3;
            p2_q <= n2;
            p1_q <= n1;
            p0_q <= m0;
        end else if (shift) begin
            p3_q <= p2_q;
            p2_q <= p1_q;
            p1_q <= p0_q;
            p0_q <= '0;
        end
    end

    assign p3 = p3_q;

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS encoder over GF(2^5), t=2: K data symbols pass through, then 4 parity symbols.
module rs_encoder
    import rs_pkg::*;
#(
    parameter int unsigned K = 27
) (
    input  logic      clock,
    input  logic      reset_n,
    rs_encoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(N_MAX);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] PAR_LAST  = CNT_W'(NPAR - 1);

    rs_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    sym_t             out_sym_q;
    logic             out_valid_q;
    logic             out_last_q;

    sym_t p3, fb;
    logic slot_free, in_ready, accept, par_emit;

    // in_ready is gated by reset_n so it reads 0 while reset is held.
    always_comb begin
        slot_free = !out_valid_q || bus.out_ready;
        in_ready  = reset_n && (state_q == DATA) && slot_free;
        accept    = bus.in_valid && in_ready;
        par_emit  = (state_q == PARITY) && slot_free;
    end

    gfadder u_fb (.a(bus.in_sym), .b(p3), .y(fb));

    rs_parity_lfsr u_lfsr (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (accept),
        .shift  (par_emit),
        .fb     (fb),
        .p3     (p3)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DATA;
            cnt_q       <= '0;
            out_sym_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (slot_free) begin
            unique case (state_q)
                DATA: begin
                    if (accept) begin
                        out_sym_q   <= bus.in_sym;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        if (cnt_q == DATA_LAST) begin
                            state_q <= PARITY;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                PARITY: begin
                    out_sym_q   <= p3;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (cnt_q == PAR_LAST);
                    if (cnt_q == PAR_LAST) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder: a K=27 instance and a shortened K=5 instance.
module tb_rs_encoder;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   stall_en = 1'b0;
    int   stall_viol = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    rs_encoder_if bus_a ();
    rs_encoder_if bus_b ();

    rs_encoder #(.K(27)) dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
    rs_encoder #(.K(5))  dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

    logic [4:0] qa_sym[$];
    logic       qa_last[$];
    logic [4:0] qb_sym[$];
    logic       qb_last[$];
    int         qb_cyc[$];
    logic       prev_stall = 1'b0;
    logic [4:0] prev_sym = '0;

    always @(posedge clock) begin
        #1;
        bus_a.out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clock) begin
        if (bus_a.out_valid && bus_a.out_ready) begin
            qa_sym.push_back(bus_a.out_sym);
            qa_last.push_back(bus_a.out_last);
        end
        if (prev_stall && (!bus_a.out_valid || bus_a.out_sym !== prev_sym)) stall_viol++;
        prev_stall = reset_n && bus_a.out_valid && !bus_a.out_ready;
        prev_sym   = bus_a.out_sym;
        if (bus_b.out_valid && bus_b.out_ready) begin
            qb_sym.push_back(bus_b.out_sym);
            qb_last.push_back(bus_b.out_last);
            qb_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input bit to_b, input logic [4:0] s);
        int n = 0;
        if (to_b) begin bus_b.in_valid = 1'b1; bus_b.in_sym = s; end
        else begin bus_a.in_valid = 1'b1; bus_a.in_sym = s; end
        @(negedge clock);
        while (!(to_b ? bus_b.in_ready : bus_a.in_ready) && n < 200) begin
            n++;
            @(negedge clock);
        end
        check("send_timeout", (n < 200) ? 1 : 0, 1);
        @(posedge clock);
        #1;
    endtask

    // Junk on in_sym while idle must be ignored.
    task automatic idle(input bit to_b);
        if (to_b) begin bus_b.in_valid = 1'b0; bus_b.in_sym = 5'($urandom_range(0, 31)); end
        else begin bus_a.in_valid = 1'b0; bus_a.in_sym = 5'($urandom_range(0, 31)); end
    endtask

    task automatic wait_count(input bit to_b, input int n, input string tag);
        int k = 0;
        while ((to_b ? qb_sym.size() : qa_sym.size()) < n && k < 1000) begin
            @(posedge clock);
            k++;
        end
        repeat (8) @(posedge clock);
        #1;
        check(tag, to_b ? qb_sym.size() : qa_sym.size(), n);
    endtask

    task automatic ready_gap(input string tag);
        int n = 0;
        @(negedge clock);
        while (!bus_a.in_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        check(tag, n, 4);
    endtask

    function automatic logic [4:0] tb_mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        logic [4:0] x;
        r = '0;
        x = b;
        for (int i = 0; i < 5; i++) begin
            if (a[i]) r = r ^ x;
            x = {x[3:0], 1'b0} ^ (x[4] ? 5'b00101 : 5'b00000);
        end
        return r;
    endfunction

    function automatic logic [4:0] syndrome(input int base, input int j);
        logic [4:0] aj;
        logic [4:0] s;
        aj = 5'd1;
        for (int k = 0; k < j; k++) aj = tb_mul(aj, 5'd2);
        s = '0;
        for (int i = 0; i < 31; i++) s = tb_mul(s, aj) ^ qa_sym[base + i];
        return s;
    endfunction

    task automatic check_parity(input string tag, input int p3, input int p2, input int p1,
                                input int p0);
        int nl = 0;
        check({tag, "_p3"}, int'(qa_sym[27]), p3);
        check({tag, "_p2"}, int'(qa_sym[28]), p2);
        check({tag, "_p1"}, int'(qa_sym[29]), p1);
        check({tag, "_p0"}, int'(qa_sym[30]), p0);
        for (int i = 0; i < 31; i++) nl += int'(qa_last[i]);
        check({tag, "_last_count"}, nl, 1);
        check({tag, "_last_pos"}, int'(qa_last[30]), 1);
    endtask

    int         msg[81];
    int         bad;
    int         exp9[9] = '{0, 0, 0, 0, 1, 30, 6, 9, 17};

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_sym = '0;
        bus_b.in_valid = 1'b0; bus_b.in_sym = '0; bus_b.out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", int'(bus_a.out_valid), 0);
        check("rst_out_sym", int'(bus_a.out_sym), 0);
        check("rst_out_last", int'(bus_a.out_last), 0);
        check("rst_in_ready", int'(bus_a.in_ready), 0);
        #19 reset_n = 1'b1;
        #1 check("ready_after_rst", int'(bus_a.in_ready), 1);
        @(posedge clock);
        #1;

        // Impulse message: parity equals g(x) low coefficients
        for (int i = 0; i < 26; i++) send(0, 5'd0);
        send(0, 5'd1);
        idle(0);
        ready_gap("impulse_ready_gap");
        wait_count(0, 31, "impulse_count");
        check("impulse_d25", int'(qa_sym[25]), 0);
        check("impulse_d26", int'(qa_sym[26]), 1);
        check_parity("impulse", 30, 6, 9, 17);

        // Alpha message
        qa_sym.delete(); qa_last.delete();
        for (int i = 0; i < 26; i++) send(0, 5'd0);
        send(0, 5'd2);
        idle(0);
        wait_count(0, 31, "alpha_count");
        check("alpha_d26", int'(qa_sym[26]), 2);
        check_parity("alpha", 25, 12, 18, 7);

        // All-zero message
        qa_sym.delete(); qa_last.delete();
        for (int i = 0; i < 27; i++) send(0, 5'd0);
        idle(0);
        ready_gap("zero_ready_gap");
        wait_count(0, 31, "zero_count");
        bad = 0;
        for (int i = 0; i < 31; i++) if (qa_sym[i] != 5'd0) bad++;
        check("zero_nonzero_syms", bad, 0);
        check_parity("zero", 0, 0, 0, 0);

        // Random messages with input gaps and output stalls
        qa_sym.delete(); qa_last.delete();
        stall_en = 1'b1;
        for (int i = 0; i < 81; i++) msg[i] = $urandom_range(0, 31);
        for (int i = 0; i < 81; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(0);
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1;
            end
            send(0, 5'(msg[i]));
        end
        idle(0);
        wait_count(0, 93, "rand_count");
        stall_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bad = 0;
            for (int i = 0; i < 27; i++) if (int'(qa_sym[c*31 + i]) != msg[c*27 + i]) bad++;
            check($sformatf("rand_data_cw%0d", c), bad, 0);
            check($sformatf("rand_last_cw%0d", c), int'(qa_last[c*31 + 30]), 1);
            for (int j = 1; j <= 4; j++)
                check($sformatf("rand_syn%0d_cw%0d", j, c), int'(syndrome(c*31, j)), 0);
        end
        check("rand_stall_stability", stall_viol, 0);
        @(posedge clock);
        #1;

        // Shortened K=5, two back-to-back codewords
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) send(1, 5'd0);
            send(1, 5'd1);
        end
        idle(1);
        wait_count(1, 18, "short_count");
        bad = 0;
        for (int i = 0; i < 18; i++) if (int'(qb_sym[i]) != exp9[i % 9]) bad++;
        check("short_symbols", bad, 0);
        check("short_last_cw0", int'(qb_last[8]), 1);
        check("short_last_cw1", int'(qb_last[17]), 1);
        check("short_last_data", int'(qb_last[4]), 0);
        check("short_no_idle", qb_cyc[17] - qb_cyc[0], 17);

        // Reset mid-codeword
        for (int i = 0; i < 10; i++) send(0, 5'(i + 3));
        idle(0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus_a.out_valid), 0);
        check("midrst_out_sym", int'(bus_a.out_sym), 0);
        check("midrst_out_last", int'(bus_a.out_last), 0);
        check("midrst_in_ready", int'(bus_a.in_ready), 0);
        @(negedge clock);
        reset_n = 1'b1;
        qa_sym.delete(); qa_last.delete();
        @(posedge clock);
        #1;
        for (int i = 0; i < 26; i++) send(0, 5'd0);
        send(0, 5'd1);
        idle(0);
        wait_count(0, 31, "postrst_count");
        check_parity("postrst", 30, 6, 9, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon encoder over GF(2^5) with field polynomial p(x)=x^5+x^2+1 and 4 parity symbols (t=2). It is the transmit-side counterpart of the RS decoder: it produces the codewords the decoder consumes. Each codeword is K data symbols passed through unchanged, followed by 4 parity symbols. The generator is g(x)=(x+α)(x+α^2)(x+α^3)(x+α^4) = x^4 + 30x^3 + 6x^2 + 9x + 17, with α = 5'b00010.

## Interface
- K, 27, data symbols per codeword; legal range 1..27; K<27 gives a shortened code; codeword length is K+4
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_sym holds a data symbol
- in_sym  in  5  data symbol, bit 4 = MSB (x^4 coefficient), polynomial basis
- in_ready  out  1  encoder accepts in_sym this cycle
- out_valid  out  1  out_sym holds a codeword symbol
- out_sym  out  5  codeword symbol, same bit order as in_sym
- out_last  out  1  out_sym is the final parity symbol of a codeword
- out_ready  in  1  downstream accepts out_sym this cycle

## Operation
- FSM states:
  - DATA: counter cnt runs 0..K-1.
  - PARITY: counter cnt runs 0..3.
- Reset state is DATA, cnt=0.
- Output register slot is free when !out_valid || out_ready.
- in_ready = (state==DATA) && slot free.
- Input accept when in_valid && in_ready:
  - out_sym <= in_sym, out_valid <= 1.
  - LFSR update with fb = in_sym ^ p3: p3<=p2^(30·fb), p2<=p1^(6·fb), p1<=p0^(9·fb), p0<=17·fb.
  - All products are GF(2^5) multiplications; all sums are XOR.
  - If cnt==K-1: state <= PARITY, cnt <= 0. Otherwise cnt++.
- PARITY, slot free:
  - out_sym <= p3, out_valid <= 1, out_last <= (cnt==3).
  - Shift p3<=p2, p2<=p1, p1<=p0, p0<=0.
  - If cnt==3: state <= DATA, cnt <= 0, LFSR is all zero. Otherwise cnt++.
- DATA with no accept and slot free: out_valid <= 0, out_last <= 0.
- Slot not free: out_sym, out_valid, out_last and the LFSR hold.
- Parity symbols are emitted highest-degree first (p3..p0).
- Shortened codes use no prefix padding: the LFSR starts at zero, which is equivalent to leading zero symbols.

## Timing
- All outputs reset to 0: out_valid=0, out_sym=0, out_last=0, in_ready=0 while reset_n is low.
- After reset release, in_ready=1 on the first cycle.
- Latency: an accepted input symbol appears on out_sym the next cycle.
- Full throughput is one symbol per cycle when out_ready=1.
- A codeword occupies K+4 output transfers.
- in_ready is low for exactly 4 cycles after the last data symbol is accepted (out_ready=1 throughout).
- Back-to-back codewords: the first data symbol of the next codeword is accepted in the cycle the final parity symbol is loaded into the output register.
- in_valid low mid-codeword inserts bubbles (out_valid=0). It does not alter cnt or parity.
- out_ready low holds all state, including during PARITY.
- out_ready is not required to be high for the output register to load when out_valid=0.
- reset_n asserted mid-codeword aborts the codeword immediately: state DATA, cnt=0, LFSR=0, outputs 0. No partial parity is emitted.
- in_sym is ignored whenever in_valid && in_ready is false.

## Structure
- Shared package rs_pkg:
  - SYM_W=5, NPAR=4, N_MAX=31
  - Field polynomial constant
  - Generator coefficients G0..G3 = 17, 9, 6, 30
  - FSM state typedef {DATA, PARITY}
- Sub-module rs_parity_lfsr: the 4-stage parity register.
  - Inputs: fb, load/shift/hold controls.
  - Output: p3.
  - Uses lcpmult for the coefficient products (constant inputs) and gfadder for the XORs.
- rs_encoder contains the FSM, counter and output register.

## Test plan
- K=27, 26 zero symbols then symbol 1 → out_sym: 26 zeros, 1, then parity 30, 6, 9, 17; out_last only on the 17.
- K=27, 26 zeros then symbol 2 (α) → data passed through, parity 25, 12, 18, 7.
- All-zero message, K=27 → 31 zero symbols; out_last on the 31st; in_ready low for 4 cycles after the 27th accept.
- Random messages with random in_valid gaps and random out_ready stalls against a reference model:
  - Every codeword's syndromes at α^1..α^4 are 0.
  - No symbol is dropped or duplicated.
  - out_sym is stable while out_valid && !out_ready.
- K=5 shortened code, message 0, 0, 0, 0, 1 → 0, 0, 0, 0, 1, 30, 6, 9, 17. Two back-to-back codewords show no idle cycle between them.
- reset_n pulsed low after 10 accepted symbols → outputs 0 asynchronously. A following impulse message (26 zeros, 1) still yields parity 30, 6, 9, 17.
